text_buffer: RTL and testbench

// Character-cell screen memory feeding the font renderer: holds one 8-bit ASCII code per text cell.

---
 rtl/text_buffer_if.sv | 13 +
 rtl/text_buffer.sv | 221 ++++++++++++++++++++++
 tb/tb_text_buffer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_buffer_if.sv
// Character write channel into the text buffer.
// The producer drives wr_valid and wr_char. The buffer returns wr_ready.
//   wr_valid : producer presents wr_char this cycle
//   wr_ready : buffer accepts wr_char this cycle
//   wr_char  : ASCII code to place, or a control code (LF/CR/FF)
interface text_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;

  modport master (output wr_valid, output wr_char, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_char, output wr_ready);
endinterface

// File: rtl/text_buffer.sv
// Character-cell screen memory for the font renderer.
// Holds one ASCII code per text cell and places incoming characters at a hardware cursor.
// LF, CR and FF act as control codes. Any other code is stored in the cell.
// Reset and FF blank the whole screen. A row advance blanks the new row.
// The render pipeline reads cells through a registered read port with 1-cycle latency.
// That port returns the old contents when the same cell is written in the same cycle.
// Ports:
//   px_clk     : pixel clock; all logic on posedge
//   rst        : synchronous active-high reset
//   wr         : valid/ready character channel (text_buffer_if slave)
//   rd_col     : read column (render stage)
//   rd_row     : read row (render stage)
//   rd_char    : code at (rd_col, rd_row), one cycle later; 8'h00 when out of range
//   cursor_col : column of next write
//   cursor_row : row of next write
//   busy       : screen or line clear in progress (== !wr_ready)
module text_buffer #(
  parameter  int unsigned COLS  = 20,
  parameter  int unsigned ROWS  = 15,
  parameter  logic [7:0]  BLANK = 8'h20,
  localparam int unsigned CW    = $clog2(COLS),
  localparam int unsigned RW    = $clog2(ROWS)
) (
  input  logic            px_clk,
  input  logic            rst,
  text_buffer_if.slave    wr,
  input  logic [CW-1:0]   rd_col,
  input  logic [RW-1:0]   rd_row,
  output logic [7:0]      rd_char,
  output logic [CW-1:0]   cursor_col,
  output logic [RW-1:0]   cursor_row,
  output logic            busy
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);

  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [AW-1:0] CELL_LAST = AW'(CELLS - 1);

  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_CR = 8'h0D;
  localparam logic [7:0] CODE_FF = 8'h0C;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_LINE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [7:0]    r_mem [CELLS];
  logic [7:0]    r_rd_char;
  logic [CW-1:0] r_cur_col;
  logic [RW-1:0] r_cur_row;
  logic [AW-1:0] r_clr_addr;
  logic [CW-1:0] r_clr_col;

  logic          w_ready;
  logic          w_xfer;
  logic          w_is_lf;
  logic          w_is_cr;
  logic          w_is_ff;
  logic          w_is_ctrl;
  logic          w_col_wrap;
  logic          w_row_adv;
  logic [RW-1:0] w_row_inc;
  logic [AW-1:0] w_cur_addr;
  logic [AW-1:0] w_line_addr;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_oob;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;

  // Ready is a pure state decode, so a transfer never loops back through wr_valid.
  assign w_ready   = (r_state == IDLE);
  assign w_xfer    = wr.wr_valid & w_ready;

  assign w_is_lf   = (wr.wr_char == CODE_LF);
  assign w_is_cr   = (wr.wr_char == CODE_CR);
  assign w_is_ff   = (wr.wr_char == CODE_FF);
  assign w_is_ctrl = w_is_lf | w_is_cr | w_is_ff;

  assign w_col_wrap = (r_cur_col == COL_LAST);
  // A row advance comes from LF, or from a stored character in the last column.
  assign w_row_adv  = w_xfer & (w_is_lf | (~w_is_ctrl & w_col_wrap));
  assign w_row_inc  = (r_cur_row == ROW_LAST) ? '0 : r_cur_row + 1'b1;

  assign w_cur_addr  = AW'(r_cur_row) * AW'(COLS) + AW'(r_cur_col);
  assign w_line_addr = AW'(r_cur_row) * AW'(COLS) + AW'(r_clr_col);
  assign w_rd_addr   = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
  assign w_rd_oob    = (rd_col > COL_LAST) | (rd_row > ROW_LAST);

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_state <= CLR_ALL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CLR_ALL: begin
        if (r_clr_addr == CELL_LAST) begin
          w_next_state = IDLE;
        end
      end
      IDLE: begin
        if (w_xfer && w_is_ff) begin
          w_next_state = CLR_ALL;
        end else if (w_row_adv) begin
          w_next_state = CLR_LINE;
        end
      end
      CLR_LINE: begin
        if (r_clr_col == COL_LAST) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = CLR_ALL;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs and memory write port
  // ---------------------------------------------------------------
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_cur_addr;
    w_wdata = wr.wr_char;
    case (r_state)
      CLR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
        w_wdata = BLANK;
      end
      IDLE: begin
        w_we = w_xfer & ~w_is_ctrl;
      end
      CLR_LINE: begin
        w_we    = 1'b1;
        w_waddr = w_line_addr;
        w_wdata = BLANK;
      end
      default: w_we = 1'b0;
    endcase
  end

  assign wr.wr_ready = w_ready;
  assign busy        = ~w_ready;

  // ---------------------------------------------------------------
  // Cursor and clear counters
  // ---------------------------------------------------------------
  // Clear counters stay at zero outside their own state.
  // Each clear therefore starts from cell/column 0 without extra control.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_cur_col  <= '0;
      r_cur_row  <= '0;
      r_clr_addr <= '0;
      r_clr_col  <= '0;
    end else begin
      r_clr_addr <= (r_state == CLR_ALL)  ? r_clr_addr + 1'b1 : '0;
      r_clr_col  <= (r_state == CLR_LINE) ? r_clr_col + 1'b1  : '0;
      if (w_xfer) begin
        if (w_is_ff) begin
          r_cur_col <= '0;
          r_cur_row <= '0;
        end else if (w_is_lf) begin
          r_cur_col <= '0;
          r_cur_row <= w_row_inc;
        end else if (w_is_cr) begin
          r_cur_col <= '0;
        end else if (w_col_wrap) begin
          r_cur_col <= '0;
          r_cur_row <= w_row_inc;
        end else begin
          r_cur_col <= r_cur_col + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Cell memory: one write port, one registered read port
  // ---------------------------------------------------------------
  always_ff @(posedge px_clk) begin
    if (!rst && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Read before write: a same-cycle write to the same cell shows on the next read.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_rd_char <= '0;
    end else if (w_rd_oob) begin
      r_rd_char <= '0;
    end else begin
      r_rd_char <= r_mem[w_rd_addr];
    end
  end

  assign rd_char    = r_rd_char;
  assign cursor_col = r_cur_col;
  assign cursor_row = r_cur_row;

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer.
// The screen model is an array of cells plus a cursor, updated per accepted character.
// Expected clear durations come from that model.
module tb_text_buffer;

  localparam int unsigned COLS  = 20;
  localparam int unsigned ROWS  = 15;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam logic [7:0]  BLANK = 8'h20;

  logic       px_clk = 1'b0;
  logic       rst;
  logic [4:0] rd_col;
  logic [3:0] rd_row;
  logic [7:0] rd_char;
  logic [4:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;

  text_buffer_if u_if ();

  text_buffer dut (
    .px_clk     (px_clk),
    .rst        (rst),
    .wr         (u_if),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 px_clk = ~px_clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  m_mem [CELLS];
  int unsigned m_col;
  int unsigned m_row;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void m_reset();
    for (int i = 0; i < int'(CELLS); i++) m_mem[i] = BLANK;
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic int unsigned m_next_row();
    m_row = (m_row + 1) % ROWS;
    for (int unsigned c = 0; c < COLS; c++) m_mem[m_row*COLS + c] = BLANK;
    return COLS;
  endfunction

  // Applies one accepted code and returns the expected number of busy cycles.
  function automatic int unsigned m_apply(input logic [7:0] code);
    int unsigned blen = 0;
    case (code)
      8'h0A: begin m_col = 0; blen = m_next_row(); end
      8'h0D: m_col = 0;
      8'h0C: begin m_reset(); blen = CELLS; end
      default: begin
        m_mem[m_row*COLS + m_col] = code;
        if (m_col == COLS - 1) begin
          m_col = 0;
          blen  = m_next_row();
        end else begin
          m_col++;
        end
      end
    endcase
    return blen;
  endfunction

  function automatic logic [7:0] m_read(input int unsigned c, input int unsigned r);
    if (c >= COLS || r >= ROWS) return 8'h00;
    return m_mem[r*COLS + c];
  endfunction

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(33, 126));
  endfunction

  // ---------------- drivers / checkers (enter and leave on negedge) ----------------
  task automatic count_busy(input string tag, input int unsigned exp);
    int unsigned cnt = 0;
    while (busy === 1'b1 && cnt < 2*CELLS + 10) begin
      cnt++;
      @(negedge px_clk);
    end
    check_eq(tag, cnt, exp);
  endtask

  task automatic check_cursor(input string tag);
    check_eq({tag, "_col"}, cursor_col, m_col);
    check_eq({tag, "_row"}, cursor_row, m_row);
  endtask

  task automatic do_reset(input logic hold_valid);
    rst = 1'b1;
    u_if.wr_valid = hold_valid;
    u_if.wr_char  = 8'h51;
    @(negedge px_clk);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_ready", u_if.wr_ready, 0);
    check_eq("rst_rdchar", rd_char, 8'h00);
    check_eq("rst_col", cursor_col, 0);
    check_eq("rst_row", cursor_row, 0);
    rst = 1'b0;
    u_if.wr_valid = 1'b0;
    m_reset();
    count_busy("clr_all_len", CELLS);
    check_eq("post_rst_ready", u_if.wr_ready, 1);
    check_cursor("post_rst");
  endtask

  task automatic wait_ready(input string tag);
    int unsigned guard = 0;
    while (u_if.wr_ready !== 1'b1 && guard < 2*CELLS) begin
      guard++;
      @(negedge px_clk);
    end
    check_eq(tag, u_if.wr_ready, 1);
  endtask

  task automatic send(input logic [7:0] code);
    int unsigned blen;
    wait_ready("send_ready");
    u_if.wr_valid = 1'b1;
    u_if.wr_char  = code;
    @(negedge px_clk);
    u_if.wr_valid = 1'b0;
    u_if.wr_char  = 8'($urandom);
    blen = m_apply(code);
    check_cursor("cursor");
    count_busy("busy_len", blen);
  endtask

  task automatic scan(input string tag);
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        rd_col = 5'(c);
        rd_row = 4'(r);
        @(negedge px_clk);
        check_eq(tag, rd_char, m_read(c, r));
      end
    end
  endtask

  task automatic read_at(input string tag, input int unsigned c, input int unsigned r);
    rd_col = 5'(c);
    rd_row = 4'(r);
    @(negedge px_clk);
    check_eq(tag, rd_char, m_read(c, r));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned pick;
    int unsigned gap;
    logic [7:0]  code;

    rst = 1'b1;
    u_if.wr_valid = 1'b0;
    u_if.wr_char  = 8'h00;
    rd_col = '0;
    rd_row = '0;
    @(negedge px_clk);

    // Power-up clear, whole screen blank.
    do_reset(1'b0);
    scan("t1_blank");

    // Two characters, read latency and read-before-write.
    send(8'h41);
    send(8'h42);
    read_at("t2_cell00", 0, 0);
    rd_col = 5'd1;
    #1;
    check_eq("t2_latency", rd_char, 8'h41);
    @(negedge px_clk);
    check_eq("t2_cell10", rd_char, 8'h42);
    rd_col = 5'd2;
    rd_row = 4'd0;
    @(negedge px_clk);
    send(8'h43);
    check_eq("t2_rbw_old", rd_char, BLANK);
    @(negedge px_clk);
    check_eq("t2_rbw_new", rd_char, 8'h43);

    // A full line wraps to row 1 and blanks it.
    do_reset(1'b0);
    for (int i = 0; i < int'(COLS); i++) send(rand_print());
    scan("t3_line");

    // LF from the last row wraps to row 0, and only row 0 is blanked.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) send(rand_print());
    send(8'h0D);
    for (int i = 0; i < int'(ROWS) - 1; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(rand_print());
    send(8'h0A);
    scan("t4_wrap");
    for (int i = 0; i < 3; i++) send(rand_print());
    send(8'h0D);

    // FF with wr_valid held high: nothing is accepted until the clear finishes.
    wait_ready("t5_ready");
    u_if.wr_valid = 1'b1;
    u_if.wr_char  = 8'h0C;
    @(negedge px_clk);
    u_if.wr_char = 8'h55;
    void'(m_apply(8'h0C));
    check_cursor("t5_ff");
    count_busy("t5_ff_len", CELLS);
    check_cursor("t5_held");
    @(negedge px_clk);
    u_if.wr_valid = 1'b0;
    void'(m_apply(8'h55));
    check_cursor("t5_after");
    scan("t5_screen");

    // Out-of-range reads, then reset during a line clear and during a transfer.
    read_at("t6_col20", 20, 0);
    read_at("t6_row15", 0, 15);
    read_at("t6_col31row15", 31, 15);
    read_at("t6_inrange", 0, 0);
    wait_ready("t6_ready");
    u_if.wr_valid = 1'b1;
    u_if.wr_char  = 8'h0A;
    @(negedge px_clk);
    u_if.wr_valid = 1'b0;
    repeat (5) @(negedge px_clk);
    check_eq("t6_mid_clr_busy", busy, 1);
    do_reset(1'b0);
    send(8'h4B);
    do_reset(1'b1);
    scan("t6_after_rst");

    // Random mix of characters, control codes, idle gaps, reads and resets.
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 99);
      if (pick < 2) begin
        send(8'h0C);
      end else if (pick < 10) begin
        send(8'h0A);
      end else if (pick < 16) begin
        send(8'h0D);
      end else if (pick < 22) begin
        gap = $urandom_range(1, 4);
        repeat (gap) begin
          u_if.wr_valid = 1'b0;
          u_if.wr_char  = 8'($urandom);
          @(negedge px_clk);
        end
        check_cursor("rnd_idle");
        check_eq("rnd_idle_busy", busy, 0);
      end else if (pick < 30) begin
        read_at("rnd_read", $urandom_range(0, 31), $urandom_range(0, 15));
      end else if (pick < 31) begin
        do_reset($urandom_range(0, 1) == 1);
      end else if (pick < 40) begin
        code = 8'($urandom);
        if (code == 8'h0A || code == 8'h0C || code == 8'h0D) code = 8'h7F;
        send(code);
      end else begin
        send(rand_print());
      end
    end
    scan("rnd_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
